// File: rtl/fir_data_tx_pkg.sv
// Shared constants for the FIR sample transmitter: default sizes, the
// count width and the binary encoding of the stream FSM states.
package fir_data_tx_pkg;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/fir_data_tx_sample_fifo.sv
// Synchronous sample FIFO. Besides the head word it exposes the word
// behind the head so the transmitter can stream back-to-back without a
// bubble. A push while full is only accepted when a pop frees a slot in
// the same cycle.
module sample_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head,
  output logic [DATA_W-1:0]        head_next,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign push_ok   = push && (!full || pop);
  assign pop_ok    = pop && !empty;
  assign head      = mem[rd_ptr];
  assign head_next = mem[rd_ptr + PTR_W'(1)];

  // Storage write; when full with a pop, the new word lands in the slot
  // being vacated, which becomes the tail.
  // NOTE: the storage array has no reset; validity is tracked solely by
  // the pointers and count, so resetting it would only cost flops.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fir_data_tx.sv
// Streams buffered samples as one-cycle data_valid strobes spaced gap+1
// cycles apart. The data register is loaded with the head word on the edge
// that enters SEND, and the FIFO pops at the end of that SEND cycle, so a
// push during SEND while full coincides with the pop and is kept.
module fir_data_tx #(
  parameter int DATA_W = fir_data_tx_pkg::DATA_W,
  parameter int DEPTH  = fir_data_tx_pkg::DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     start,
  input  logic [3:0]               gap,
  output logic                     data_valid,
  output logic [DATA_W-1:0]        data,
  output logic                     busy,
  output logic                     done,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  import fir_data_tx_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]        state_q, state_d;
  logic [3:0]        gap_q;
  logic [3:0]        wait_q, wait_d;
  logic              pop;
  logic              empty;
  logic              last;
  logic [DATA_W-1:0] head, head_next, load_word;

  sample_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .head      (head),
    .head_next (head_next),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // The SEND word is the last one unless a push arrives in the same cycle.
  assign last = (count == CW'(1)) && !wr_en;

  // Next-state, pop request and the word to present on the next strobe.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    pop       = 1'b0;
    load_word = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (!empty) begin
            state_d   = ST_SEND;
            load_word = head;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_SEND: begin
        pop = 1'b1;
        if (last) begin
          state_d = ST_DONE;
        end else if (gap_q == 4'd0) begin
          state_d   = ST_SEND;
          // After this pop the new head is the word behind it, or the word
          // being pushed right now when only one was left.
          load_word = (count > CW'(1)) ? head_next : wr_data;
        end else begin
          state_d = ST_WAIT;
          wait_d  = gap_q - 4'd1;
        end
      end
      ST_WAIT: begin
        if (wait_q == 4'd0) begin
          state_d   = ST_SEND;
          load_word = head;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, gap latch, pacing counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      gap_q      <= '0;
      wait_q     <= '0;
      data_valid <= 1'b0;
      data       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      if (state_q == ST_IDLE && start && !empty) gap_q <= gap;
      data_valid <= (state_d == ST_SEND);
      data       <= load_word;
      busy       <= (state_d == ST_SEND) || (state_d == ST_WAIT);
      done       <= (state_d == ST_DONE);
    end
  end

endmodule

// File: doc/fir_data_tx.md
FIR_DATA_TX -- requirements
Module: fir_data_tx

Interface
REQ-001 Parameter DATA_W, 16, sample width in bits.
REQ-002 Parameter DEPTH, 16, sample buffer depth in words (power of two).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 wr_en  input  1  push wr_data into the buffer this cycle.
REQ-006 wr_data  input  DATA_W  two's-complement sample to buffer.
REQ-007 start  input  1  one-cycle request to stream the buffer contents.
REQ-008 gap  input  4  idle cycles between consecutive samples, latched at start.
REQ-009 data_valid  output  1  one-cycle strobe per transmitted sample, FIR-input compatible.
REQ-010 data  output  DATA_W  transmitted sample; 0 whenever data_valid is low.
REQ-011 busy  output  1  high from the accepted start until done.
REQ-012 done  output  1  one-cycle pulse at end of stream.
REQ-013 full  output  1  buffer holds DEPTH words.
REQ-014 count  output  5  words currently buffered, range 0..DEPTH.

Function
REQ-015 FSM states: IDLE, SEND, WAIT, DONE; encoding is binary.
REQ-016 IDLE: start with count>0 latches gap, asserts busy and enters SEND next edge; start with count==0 enters DONE directly (zero-sample stream).
REQ-017 SEND: pops the buffer head into the data register with data_valid=1 for exactly one cycle.
REQ-018 First data_valid appears on the cycle immediately after the start cycle (latency 1).
REQ-019 After SEND: if buffer now empty -> DONE; else if latched gap==0 -> SEND again (back-to-back strobes); else WAIT for gap cycles, then SEND.
REQ-020 Consecutive data_valid strobes are spaced exactly gap+1 cycles apart.
REQ-021 DONE: done=1 for one cycle, busy deasserts on the same edge, and the FSM returns to IDLE.
REQ-022 start outside IDLE is ignored; gap changes after start are ignored until the next stream.
REQ-023 Writes are permitted in every state; a word written before the buffer empties is transmitted in the same stream, in FIFO order.
REQ-024 wr_en while full with no pop in the same cycle is dropped; count and contents are unchanged.
REQ-025 wr_en while full with a pop in the same cycle is accepted; count stays DEPTH.
REQ-026 Simultaneous push and pop leave count unchanged; pointers wrap modulo DEPTH.
REQ-027 data is passed bit-exact with no sign or width conversion.
REQ-028 All outputs are registered or derived only from registered count.

Reset
REQ-029 rst low asynchronously forces: state=IDLE, data_valid=0, data=0, busy=0, done=0, count=0, full=0, pointers=0, gap latch=0.
REQ-030 Reset mid-stream discards buffered samples; no data_valid is generated after release until a new start.
REQ-031 First start is honoured on the first clock edge with rst high.

Structure
REQ-032 Shared package holds DATA_W, DEPTH, the count width, and the FSM state encodings.
REQ-033 Buffer is a sub-module sample_fifo (synchronous FIFO with push, pop, full, empty, count); FSM and pacing counter live in fir_data_tx.

Verification
REQ-034 Write 3 samples 0x0001, 0xFFFF, 0x7FFF; start with gap=0 -> data_valid on 3 consecutive cycles starting 1 cycle after start, data in that order, done in the 4th cycle.
REQ-035 Write 2 samples; start with gap=3 -> strobes 4 cycles apart, data=0 between strobes, busy high throughout, done 1 cycle after the second strobe.
REQ-036 Write 17 words 0..16 into an empty buffer -> full=1, count=16, word 16 dropped; stream with gap=0 -> data 0..15 only.
REQ-037 Start with an empty buffer -> no data_valid; done pulses 1 cycle later; busy stays 0.
REQ-038 Buffer full, stream with gap=1, push 0x1234 during a SEND cycle -> push accepted, count stays 16, and 0x1234 is sent last.
REQ-039 Pull rst low between strobes of a 10-word stream -> all outputs 0 immediately; after release no strobes occur, count=0 until new writes arrive.
